// File: rtl/multdiv_sequencer_if.sv
// Handshake between the control unit and the Mult/Div sequencer.
// master = control unit side, slave = sequencer side.
interface multdiv_sequencer_if;
    logic        req;
    logic        op;
    logic [31:0] divisor;
    logic        mult_start;
    logic        div_start;
    logic        mult_div_sel;
    logic        hi_wr;
    logic        lo_wr;
    logic        busy;
    logic        done;
    logic        div_zero_exc;

    modport master (
        output req, op, divisor,
        input  mult_start, div_start, mult_div_sel, hi_wr, lo_wr, busy, done, div_zero_exc
    );

    modport slave (
        input  req, op, divisor,
        output mult_start, div_start, mult_div_sel, hi_wr, lo_wr, busy, done, div_zero_exc
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequences the shared Mult/Div units and the HI/LO write for the control unit:
// start pulse, fixed iteration wait, HI/LO write, then done or divide-by-zero exception.
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               reset,
    multdiv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_WRITE,
        S_DONE,
        S_EXC
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        op_d             = op_q;
        bus.mult_start   = 1'b0;
        bus.div_start    = 1'b0;
        bus.mult_div_sel = 1'b0;
        bus.hi_wr        = 1'b0;
        bus.lo_wr        = 1'b0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.div_zero_exc = 1'b0;

        // A new request is taken on the edge that ends DONE or EXC as well as from
        // IDLE, so back-to-back operations need no idle cycle in between.
        if (state_q == S_IDLE || state_q == S_DONE || state_q == S_EXC) begin
            if (bus.req) begin
                op_d    = bus.op;
                state_d = (bus.op && bus.divisor == '0) ? S_EXC : S_START;
            end else begin
                state_d = S_IDLE;
            end
        end

        case (state_q)
            S_IDLE: begin
            end
            S_START: begin
                bus.busy         = 1'b1;
                bus.mult_start   = ~op_q;
                bus.div_start    = op_q;
                bus.mult_div_sel = op_q;
                cnt_d            = op_q ? DIV_LOAD : MULT_LOAD;
                state_d          = S_RUN;
            end
            S_RUN: begin
                bus.busy         = 1'b1;
                bus.mult_div_sel = op_q;
                if (cnt_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WRITE: begin
                bus.busy         = 1'b1;
                bus.mult_div_sel = op_q;
                bus.hi_wr        = 1'b1;
                bus.lo_wr        = 1'b1;
                state_d          = S_DONE;
            end
            S_DONE: begin
                bus.busy         = 1'b1;
                bus.mult_div_sel = op_q;
                bus.done         = 1'b1;
            end
            S_EXC: begin
                bus.busy         = 1'b1;
                bus.div_zero_exc = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench: each accepted request pushes its expected per-cycle output
// vectors; every cycle pops one vector per DUT (empty queue = idle, all zero).
module tb_multdiv_sequencer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;

    multdiv_sequencer_if bus ();
    multdiv_sequencer_if bus_f ();

    multdiv_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multdiv_sequencer #(
        .MULT_CYCLES (1),
        .DIV_CYCLES  (3)
    ) u_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mult_start, div_start, mult_div_sel, hi_wr, lo_wr, busy, done, div_zero_exc}
    logic [7:0] vec0, vec1;
    assign vec0 = {bus.mult_start, bus.div_start, bus.mult_div_sel, bus.hi_wr,
                   bus.lo_wr, bus.busy, bus.done, bus.div_zero_exc};
    assign vec1 = {bus_f.mult_start, bus_f.div_start, bus_f.mult_div_sel, bus_f.hi_wr,
                   bus_f.lo_wr, bus_f.busy, bus_f.done, bus_f.div_zero_exc};

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    function automatic logic [7:0] mk(input logic ms, input logic ds, input logic sel,
                                      input logic hi, input logic lo, input logic bsy,
                                      input logic dn, input logic exc);
        return {ms, ds, sel, hi, lo, bsy, dn, exc};
    endfunction

    // Drive a request into DUT d and push the outputs the spec timing requires.
    task automatic issue(input int d, input logic o, input logic [31:0] dv, input int n);
        logic [7:0] exp_q[$];
        if (o && dv == 32'd0) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1));
        end else begin
            exp_q.push_back(mk(~o, o, o, 0, 0, 1, 0, 0));
            for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, o, 0, 0, 1, 0, 0));
            exp_q.push_back(mk(0, 0, o, 1, 1, 1, 0, 0));
            exp_q.push_back(mk(0, 0, o, 0, 0, 1, 1, 0));
        end
        if (d == 0) begin
            bus.req = 1'b1; bus.op = o; bus.divisor = dv;
            foreach (exp_q[i]) q0.push_back(exp_q[i]);
        end else begin
            bus_f.req = 1'b1; bus_f.op = o; bus_f.divisor = dv;
            foreach (exp_q[i]) q1.push_back(exp_q[i]);
        end
    endtask

    task automatic tick();
        logic [7:0] e0, e1;
        @(posedge clk);
        #1;
        cyc++;
        e0 = '0;
        e1 = '0;
        if (q0.size() > 0) e0 = q0.pop_front();
        if (q1.size() > 0) e1 = q1.pop_front();
        n_tests++;
        assert (vec0 === e0) else begin
            n_fail++;
            $error("FAIL dut32 cyc %0d observed %b expected %b", cyc, vec0, e0);
        end
        n_tests++;
        assert (vec1 === e1) else begin
            n_fail++;
            $error("FAIL dut_fast cyc %0d observed %b expected %b", cyc, vec1, e1);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b1;
        bus.req = 1'b0;   bus.op = 1'b0;   bus.divisor = 32'd0;
        bus_f.req = 1'b0; bus_f.op = 1'b0; bus_f.divisor = 32'd0;

        // 1: reset then idle
        ticks(2);
        reset = 1'b0;
        ticks(3);

        // 2: mult, done in cycle 35, idle in 36
        issue(0, 1'b0, 32'd7, 32);
        tick();
        bus.req = 1'b0;
        ticks(35);

        // 3: div, inputs wiggled during RUN are ignored
        issue(0, 1'b1, 32'd3, 32);
        tick();
        bus.req = 1'b0;
        ticks(4);
        bus.op = 1'b0; bus.divisor = 32'd0; bus.req = 1'b1;
        ticks(3);
        bus.req = 1'b0; bus.op = 1'b1; bus.divisor = 32'd5;
        ticks(28);

        // 4: divide by zero, then an immediate mult accepted at the end of EXC
        issue(0, 1'b1, 32'd0, 0);
        tick();
        issue(0, 1'b0, 32'd9, 32);
        tick();
        bus.req = 1'b0;
        ticks(36);

        // 5: reset during RUN cycle 10 of a div abandons it
        issue(0, 1'b1, 32'd3, 32);
        tick();
        bus.req = 1'b0;
        ticks(10);
        reset = 1'b1;
        q0.delete();
        tick();
        reset = 1'b0;
        ticks(40);

        // 6: fast instance, req held with op=0 -> done every 4 cycles
        for (int k = 0; k < 5; k++) begin
            issue(1, 1'b0, 32'd1, 1);
            ticks(4);
        end
        bus_f.req = 1'b0;
        ticks(3);
        issue(1, 1'b1, 32'd2, 3);
        tick();
        bus_f.req = 1'b0;
        ticks(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
